// File: rtl/alarm_responder_if.sv
// Handshake bundle between the alarm detector side and the responder.
// Carries the request/acknowledge inputs and all registered status outputs.
interface alarm_responder_if;
  logic       L;
  logic       ack;
  logic       alarm_latched;
  logic       siren;
  logic [7:0] event_count;
  logic [1:0] state;

  modport master (
    output L,
    output ack,
    input  alarm_latched,
    input  siren,
    input  event_count,
    input  state
  );

  modport slave (
    input  L,
    input  ack,
    output alarm_latched,
    output siren,
    output event_count,
    output state
  );
endinterface

// File: rtl/alarm_responder.sv
// Debounced latched alarm with siren, operator acknowledge and rearm lockout.
// Every output comes straight from a flop; L and ack only reach next-state logic.
module alarm_responder #(
  parameter int DEBOUNCE   = 4,
  parameter int SIREN_HALF = 8,
  parameter int HOLDOFF    = 16
) (
  input logic         clk,
  input logic         rst,
  alarm_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_ALARM   = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  localparam logic [3:0] Q_LAST = 4'(DEBOUNCE - 1);
  localparam logic [7:0] S_LAST = 8'(SIREN_HALF - 1);
  localparam logic [7:0] H_LAST = 8'(HOLDOFF - 1);

  state_t     cur, nxt;
  logic [3:0] qcnt, qcnt_n;
  logic [7:0] scnt, scnt_n;
  logic [7:0] hcnt, hcnt_n;
  logic [7:0] evt, evt_n;
  logic       siren_q, siren_n;
  logic       alarm_q, alarm_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= S_IDLE;
      qcnt    <= '0;
      scnt    <= '0;
      hcnt    <= '0;
      evt     <= '0;
      siren_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      cur     <= nxt;
      qcnt    <= qcnt_n;
      scnt    <= scnt_n;
      hcnt    <= hcnt_n;
      evt     <= evt_n;
      siren_q <= siren_n;
      alarm_q <= alarm_n;
    end
  end

  always_comb begin
    nxt     = cur;
    qcnt_n  = qcnt;
    scnt_n  = scnt;
    hcnt_n  = hcnt;
    evt_n   = evt;
    siren_n = siren_q;
    case (cur)
      S_IDLE: begin
        siren_n = 1'b0;
        if (bus.L) begin
          nxt    = S_QUALIFY;
          qcnt_n = 4'd1;
        end
      end
      S_QUALIFY: begin
        if (!bus.L) begin
          nxt    = S_IDLE;
          qcnt_n = '0;
        end else if (qcnt == Q_LAST) begin
          nxt     = S_ALARM;
          qcnt_n  = '0;
          scnt_n  = '0;
          siren_n = 1'b1;
          evt_n   = (evt == 8'hFF) ? evt : evt + 8'd1;
        end else begin
          qcnt_n = qcnt + 4'd1;
        end
      end
      S_ALARM: begin
        // ack only counts once we are already latched
        if (bus.ack) begin
          nxt     = S_HOLD;
          hcnt_n  = '0;
          scnt_n  = '0;
          siren_n = 1'b0;
        end else if (scnt == S_LAST) begin
          scnt_n  = '0;
          siren_n = ~siren_q;
        end else begin
          scnt_n = scnt + 8'd1;
        end
      end
      S_HOLD: begin
        if (hcnt == H_LAST) begin
          nxt    = S_IDLE;
          hcnt_n = '0;
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end
      default: begin
        nxt     = S_IDLE;
        qcnt_n  = '0;
        scnt_n  = '0;
        hcnt_n  = '0;
        evt_n   = '0;
        siren_n = 1'b0;
      end
    endcase
    alarm_n = (nxt == S_ALARM);
  end

  assign bus.state         = cur;
  assign bus.alarm_latched = alarm_q;
  assign bus.siren         = siren_q;
  assign bus.event_count   = evt;

endmodule

// File: tb/tb_alarm_responder.sv
// Directed bench for alarm_responder with a cycle-level behavioural model.
// Model tracks run length of L, time in alarm and time in lockout.
module tb_alarm_responder;

  localparam int DB = 4;
  localparam int SH = 8;
  localparam int HO = 16;

  logic clk;
  logic rst;

  alarm_responder_if bus ();

  alarm_responder #(
    .DEBOUNCE  (DB),
    .SIREN_HALF(SH),
    .HOLDOFF   (HO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int m_st;
  int m_run;
  int m_ac;
  int m_hc;
  int m_ev;

  int total;
  int bad;

  initial begin
    m_st = 0; m_run = 0; m_ac = 0; m_hc = 0; m_ev = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_st = 0; m_run = 0; m_ac = 0; m_hc = 0; m_ev = 0;
      end else begin
        case (m_st)
          0, 1: begin
            m_run = bus.L ? m_run + 1 : 0;
            if (m_run == DB) begin
              m_st  = 2;
              m_ac  = 0;
              m_run = 0;
              m_ev  = (m_ev < 255) ? m_ev + 1 : 255;
            end else begin
              m_st = (m_run > 0) ? 1 : 0;
            end
          end
          2: begin
            if (bus.ack) begin
              m_st = 3;
              m_hc = 0;
            end else begin
              m_ac++;
            end
          end
          default: begin
            m_hc++;
            if (m_hc == HO) m_st = 0;
          end
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    int sir;
    sir = (m_st == 2 && ((m_ac / SH) % 2 == 0)) ? 1 : 0;
    chk("state", int'(bus.state), m_st);
    chk("alarm_latched", int'(bus.alarm_latched), (m_st == 2) ? 1 : 0);
    chk("siren", int'(bus.siren), sir);
    chk("event_count", int'(bus.event_count), m_ev);
  endtask

  task automatic step(input logic l, input logic a);
    bus.L   = l;
    bus.ack = a;
    @(negedge clk);
    cmp_model();
  endtask

  task automatic raise();
    for (int i = 0; i < DB; i++) step(1'b1, 1'b0);
  endtask

  task automatic ack_and_wait();
    step(1'b0, 1'b1);
    for (int i = 0; i < HO; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.L   = 1'b0;
    bus.ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", int'(bus.state), 0);
    chk("reset_count", int'(bus.event_count), 0);
    cmp_model();
    rst = 1'b0;

    // glitch shorter than the debounce window
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("glitch_qualify", int'(bus.state), 1);
    end
    step(1'b0, 1'b0);
    chk("glitch_idle", int'(bus.state), 0);
    chk("glitch_count", int'(bus.event_count), 0);

    // raise, then siren pattern with L dropped
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("pre_alarm", int'(bus.alarm_latched), 0);
    step(1'b1, 1'b0);
    chk("raise_alarm", int'(bus.alarm_latched), 1);
    chk("raise_count", int'(bus.event_count), 1);
    chk("siren_on", int'(bus.siren), 1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    chk("siren_last_hi", int'(bus.siren), 1);
    step(1'b0, 1'b0);
    chk("siren_lo", int'(bus.siren), 0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    chk("siren_last_lo", int'(bus.siren), 0);
    step(1'b0, 1'b0);
    chk("siren_hi_again", int'(bus.siren), 1);
    chk("alarm_held", int'(bus.state), 2);

    // ack with L held high through lockout
    step(1'b1, 1'b1);
    chk("ack_state", int'(bus.state), 3);
    chk("ack_alarm", int'(bus.alarm_latched), 0);
    chk("ack_siren", int'(bus.siren), 0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    chk("hold_last", int'(bus.state), 3);
    step(1'b1, 1'b0);
    chk("hold_exit", int'(bus.state), 0);
    step(1'b1, 1'b0);
    chk("rearm_qualify", int'(bus.state), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("second_alarm", int'(bus.state), 2);
    chk("second_count", int'(bus.event_count), 2);

    // ack wins over L low; ack in IDLE ignored
    step(1'b0, 1'b1);
    chk("ack_l0_state", int'(bus.state), 3);
    for (int i = 0; i < HO; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("idle_ack", int'(bus.state), 0);

    // ack held across the entry edge is not an acknowledge
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("entry_ack_ignored", int'(bus.state), 2);
    step(1'b1, 1'b1);
    chk("ack_after_entry", int'(bus.state), 3);
    for (int i = 0; i < HO; i++) step(1'b0, 1'b0);

    // async reset mid-alarm with five events
    raise();
    ack_and_wait();
    raise();
    step(1'b0, 1'b0);
    chk("pre_rst_count", int'(bus.event_count), 5);
    chk("pre_rst_state", int'(bus.state), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(bus.state), 0);
    chk("arst_alarm", int'(bus.alarm_latched), 0);
    chk("arst_siren", int'(bus.siren), 0);
    chk("arst_count", int'(bus.event_count), 0);
    @(negedge clk);
    cmp_model();
    rst = 1'b0;
    step(1'b1, 1'b0);
    chk("post_rst_qualify", int'(bus.state), 1);
    step(1'b0, 1'b0);

    // saturation
    for (int n = 0; n < 256; n++) begin
      raise();
      ack_and_wait();
    end
    chk("sat_count", int'(bus.event_count), 255);
    raise();
    chk("sat_alarm", int'(bus.state), 2);
    chk("sat_hold", int'(bus.event_count), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_responder.md
ALARM_RESPONDER -- requirements
Module: alarm_responder

Interface
REQ-001 Parameter DEBOUNCE, default 4, number of consecutive sampled-high clock edges of L required to raise an alarm (legal 2..15).
REQ-002 Parameter SIREN_HALF, default 8, siren half-period in clock cycles (legal 2..255).
REQ-003 Parameter HOLDOFF, default 16, rearm lockout in clock cycles after acknowledge (legal 1..255).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 L  input  1  alarm request from the combinational detector; synchronous to clk.
REQ-007 ack  input  1  operator acknowledge; level, sampled on clk.
REQ-008 alarm_latched  output  1  high while in ALARM.
REQ-009 siren  output  1  square-wave siren drive, active only in ALARM.
REQ-010 event_count  output  8  number of alarms raised since reset, saturating.
REQ-011 state  output  2  current FSM code: IDLE=0, QUALIFY=1, ALARM=2, HOLDOFF=3.

Function
REQ-012 All outputs SHALL be registered; no combinational path from L or ack to any output.
REQ-013 FSM SHALL have exactly four states IDLE, QUALIFY, ALARM, HOLDOFF.
REQ-014 IDLE: edge with L=1 SHALL go to QUALIFY with qualify count = 1; L=0 stays IDLE.
REQ-015 QUALIFY: edge with L=0 SHALL return to IDLE and clear qualify count.
REQ-016 QUALIFY: edge with L=1 and qualify count = DEBOUNCE-1 SHALL go to ALARM; otherwise count increments.
REQ-017 Net result: alarm_latched rises after the DEBOUNCE-th consecutive edge with L=1, i.e. latency DEBOUNCE cycles from first sampled high.
REQ-018 On the ALARM entry edge event_count SHALL increment by 1, saturating at 255 (no wrap).
REQ-019 ALARM: siren SHALL be 1 for the first SIREN_HALF cycles, then toggle every SIREN_HALF cycles while in ALARM.
REQ-020 ALARM SHALL be held regardless of L (latched alarm); L dropping has no effect.
REQ-021 ALARM: edge with ack=1 SHALL go to HOLDOFF; alarm_latched and siren SHALL be 0 from that edge.
REQ-022 ack=1 and L=0 on the same edge in ALARM: ack wins, go to HOLDOFF.
REQ-023 ack in IDLE, QUALIFY or HOLDOFF SHALL be ignored; ack held high on ALARM entry edge does not acknowledge (ack sampled only while already in ALARM).
REQ-024 HOLDOFF: L SHALL be ignored; after HOLDOFF edges in HOLDOFF the FSM SHALL go to IDLE; L evaluated from the following edge.
REQ-025 Siren and holdoff counters SHALL clear on every state entry.
REQ-026 Illegal/unreachable state code SHALL recover to IDLE on the next edge with outputs at reset values.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force state=IDLE, alarm_latched=0, siren=0, event_count=0 and clear all internal counters.
REQ-028 rst asserted mid-ALARM or mid-QUALIFY SHALL abort the operation; no count or alarm survives.
REQ-029 After rst deasserts, the first rising edge SHALL evaluate L as in IDLE.

Verification (defaults DEBOUNCE=4, SIREN_HALF=8, HOLDOFF=16)
REQ-030 Glitch reject: L high 3 edges then low -> state 0->1->1->1->0, alarm_latched never 1, event_count=0.
REQ-031 Raise and siren: L high 4 edges -> alarm_latched=1 after 4th edge, event_count=1, siren high 8 cycles, low 8 cycles, high again; L dropped afterwards -> alarm stays.
REQ-032 Acknowledge and holdoff: ack=1 one cycle in ALARM -> alarm_latched=0, siren=0, state=3; L held high throughout -> state=0 after 16 cycles, then QUALIFY and new alarm 4 edges later, event_count=2.
REQ-033 Simultaneous: ack=1 and L=0 on same edge in ALARM -> state=3; ack=1 in IDLE -> no effect.
REQ-034 Async reset: rst pulsed between edges during ALARM with event_count=5 -> outputs 0 immediately, state=0, before next clk edge.
REQ-035 Saturation: 256 raise/ack cycles -> event_count stops at 255 and stays 255 on a further alarm.
